fir_da_sequencer: RTL
=====================

# fir_da_sequencer

Parametrised control sequencer for the distributed-arithmetic (DA) FIR datapath. It replaces the fixed three-state FIR controller. The block runs three phases: a counted coefficient-load phase, a valid/ready sample-acceptance handshake, and a DATA_W-cycle bit-serial DA run per sample. Samples from NUM_CH time-multiplexed channels are handled round-robin, and every result is tagged with its channel. It sits between the input sample stream, the sample FIFO, the coefficient LUT and the DA accumulator.

## Interface
Parameters:
- DATA_W, 16, sample width in bits; one DA iteration per bit (≥2)
- COEF_DEPTH, 16, coefficient words written per load phase (≥1)
- NUM_CH, 1, interleaved channels (≥1)
- CH_W, max(1,clog2(NUM_CH)), channel index width
- BIT_W, clog2(DATA_W), bit index width
- ADDR_W, max(1,clog2(COEF_DEPTH)), coefficient address width

Ports:
- clk  in  1  sole clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; forces reset values immediately
- cload  in  1  coefficient-load request
- coef_valid  in  1  coefficient word present this cycle
- valid_in  in  1  input sample valid
- ready_in  out  1  block accepts a sample this cycle
- coef_we  out  1  LUT write strobe
- coef_addr  out  ADDR_W  LUT write address
- enable_fifo  out  1  sample FIFO shift strobe
- resetn_fifo  out  1  FIFO reset, active-low
- clear_da  out  1  accumulator clear
- shift_da  out  1  DA iteration enable
- bit_idx  out  BIT_W  current DA bit, LSB first
- last_bit  out  1  bit_idx == DATA_W-1 during RUN
- chan_out  out  CH_W  channel of the result on global_valid_out
- global_valid_out  out  1  one-cycle result-valid pulse
- overrun  out  1  sticky flag: a sample was presented while not ready

## Operation
- States:
  - IDLE: post-reset.
  - LOAD: coefficients being written.
  - READY: waiting for a sample.
  - RUN: DA iterations in progress.
- IDLE: when cload=1, go to LOAD and set coef_cnt=0.
- LOAD:
  - coef_we = coef_valid and coef_addr = coef_cnt (both combinational).
  - Each coef_valid increments coef_cnt.
  - coef_valid with coef_cnt==COEF_DEPTH-1 moves to READY and sets coef_cnt=0.
  - cload in LOAD restarts the count at 0.
- READY:
  - ready_in=1.
  - If cload=1, go to LOAD. cload has priority, and no sample is accepted that cycle (ready_in=0 when cload=1).
  - Otherwise, valid_in=1 accepts a sample: enable_fifo=1 and clear_da=1 (combinational, that cycle only). Go to RUN with bit_cnt=0 and latch the sample's channel.
- RUN:
  - shift_da=1 and bit_idx=bit_cnt.
  - bit_cnt increments each cycle.
  - On bit_cnt==DATA_W-1, return to READY. In the next cycle, global_valid_out=1 and chan_out=the latched channel.
  - The channel counter advances, wrapping from NUM_CH-1 to 0.
  - cload is ignored in RUN and takes effect only if still asserted in READY.
- resetn_fifo: 0 in IDLE and LOAD, 1 in READY and RUN. A coefficient load therefore flushes the FIFO.
- Channel counter: reset to 0 on entry to LOAD, so a reload restarts at channel 0.
- overrun:
  - Set on any cycle with valid_in=1 and ready_in=0 while not in IDLE or LOAD.
  - Cleared only by reset or on entry to LOAD.
  - Rejected samples are dropped. enable_fifo stays 0 for them.
- Unreachable state encodings return to IDLE, with all strobes 0.

## Timing
- Reset values: state IDLE, coef_cnt 0, bit_cnt 0, channel 0, chan_out 0, global_valid_out 0, overrun 0.
- Combinational outputs in IDLE: ready_in 0, coef_we 0, enable_fifo 0, clear_da 0, shift_da 0, bit_idx 0, last_bit 0, resetn_fifo 0.
- Load: COEF_DEPTH coef_valid beats, gaps allowed. READY is entered the cycle after the last beat.
- Sample latency:
  - Accept at cycle T.
  - shift_da high T+1..T+DATA_W; last_bit at T+DATA_W.
  - global_valid_out at T+DATA_W+1.
- Throughput: ready_in rises at T+DATA_W+1, so back-to-back samples are accepted every DATA_W+1 cycles.
- global_valid_out is registered, exactly one cycle wide, and never asserted in IDLE or LOAD.
- Reset asserted mid-RUN or mid-LOAD: immediate return to reset values. No result pulse is produced for the aborted sample.

## Test plan
Parameters for all scenarios: DATA_W=8, COEF_DEPTH=4, NUM_CH=2.
1. Reset, then cload for 1 cycle and 4 coef_valid beats with one idle gap → coef_addr 0,1,2,3 on the strobes; READY one cycle after the 4th beat; resetn_fifo 0 throughout LOAD.
2. Accept a sample at T → clear_da and enable_fifo at T only; shift_da T+1..T+8 with bit_idx 0..7; last_bit at T+8; global_valid_out at T+9 with chan_out=0.
3. valid_in held high for three samples → accepts 9 cycles apart; chan_out sequence 0,1,0; overrun=1 after the first rejected cycle.
4. cload and valid_in together in READY → no accept (enable_fifo 0); LOAD entered; overrun cleared; channel reset to 0.
5. Reset pulsed at T+4 of a RUN → all outputs at reset values immediately; no global_valid_out at T+9.
6. cload pulsed during RUN, deasserted before READY → ignored; the run completes normally and stays in READY.

Source files
------------

// File: rtl/fir_da_sequencer.sv
// Control sequencer for the bit-serial distributed-arithmetic FIR datapath.
// Handles the coefficient load, the sample handshake and a DATA_W-cycle DA run per sample, with channels taken round-robin.
module fir_da_sequencer #(
  parameter int DATA_W     = 16,
  parameter int COEF_DEPTH = 16,
  parameter int NUM_CH     = 1,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int BIT_W      = $clog2(DATA_W),
  parameter int ADDR_W     = (COEF_DEPTH > 1) ? $clog2(COEF_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cload,
  input  logic              coef_valid,
  input  logic              valid_in,
  output logic              ready_in,
  output logic              coef_we,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              enable_fifo,
  output logic              resetn_fifo,
  output logic              clear_da,
  output logic              shift_da,
  output logic [BIT_W-1:0]  bit_idx,
  output logic              last_bit,
  output logic [CH_W-1:0]   chan_out,
  output logic              global_valid_out,
  output logic              overrun
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY, S_RUN} state_t;

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] LAST_COEF = ADDR_W'(COEF_DEPTH - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

  state_t            state, nxt;
  logic [ADDR_W-1:0] coef_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CH_W-1:0]   ch_cnt, ch_lat;
  logic              accept, run_end, load_entry, rejected;

  always_comb begin
    nxt         = state;
    ready_in    = 1'b0;
    coef_we     = 1'b0;
    enable_fifo = 1'b0;
    clear_da    = 1'b0;
    shift_da    = 1'b0;
    bit_idx     = '0;
    last_bit    = 1'b0;
    resetn_fifo = 1'b0;
    accept      = 1'b0;
    run_end     = 1'b0;
    case (state)
      S_IDLE: if (cload) nxt = S_LOAD;
      S_LOAD: begin
        coef_we = coef_valid;
        if (!cload && coef_valid && coef_cnt == LAST_COEF) nxt = S_READY;
      end
      S_READY: begin
        resetn_fifo = 1'b1;
        // a pending reload wins over a sample offered in the same cycle
        ready_in    = !cload;
        if (cload) nxt = S_LOAD;
        else if (valid_in) begin
          accept      = 1'b1;
          enable_fifo = 1'b1;
          clear_da    = 1'b1;
          nxt         = S_RUN;
        end
      end
      S_RUN: begin
        resetn_fifo = 1'b1;
        shift_da    = 1'b1;
        bit_idx     = bit_cnt;
        last_bit    = (bit_cnt == LAST_BIT);
        run_end     = (bit_cnt == LAST_BIT);
        if (bit_cnt == LAST_BIT) nxt = S_READY;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign coef_addr  = coef_cnt;
  assign load_entry = (nxt == S_LOAD) && (state != S_LOAD);
  assign rejected   = valid_in && !ready_in && (state == S_READY || state == S_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      coef_cnt         <= '0;
      bit_cnt          <= '0;
      ch_cnt           <= '0;
      ch_lat           <= '0;
      chan_out         <= '0;
      global_valid_out <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      state            <= nxt;
      global_valid_out <= run_end;
      if (run_end) chan_out <= ch_lat;

      if (load_entry || (state == S_LOAD && cload)) coef_cnt <= '0;
      else if (state == S_LOAD && coef_valid)
        coef_cnt <= (coef_cnt == LAST_COEF) ? '0 : coef_cnt + 1'b1;

      if (accept) bit_cnt <= '0;
      else if (state == S_RUN) bit_cnt <= run_end ? '0 : bit_cnt + 1'b1;

      if (accept) ch_lat <= ch_cnt;
      if (load_entry) ch_cnt <= '0;
      else if (run_end) ch_cnt <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + 1'b1;

      // clearing on a reload takes priority over a same-cycle rejection
      if (load_entry) overrun <= 1'b0;
      else if (rejected) overrun <= 1'b1;
    end
  end

endmodule
